// File: rtl/wb_master_bridge.sv
// wb_master_bridge: command-driven Wishbone classic master.
//
// Takes one read/write command over a valid/ready handshake, runs a single
// Wishbone classic cycle and returns read data plus a status code over a
// valid/ready response channel. Only one transaction is outstanding at a time.
//
// Status codes: 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
//
// Optional feature: define WB_MASTER_BRIDGE_TIMEOUT_EN to abort an attempt
// after TIMEOUT_CYCLES silent bus cycles (status 11). Without it the bridge
// waits in the bus phase indefinitely.
//
// Ports:
//   wb_clk, wb_rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_we/cmd_adr/cmd_dat    command: write enable, address, write data
//   resp_valid/resp_ready     response handshake
//   resp_dat/resp_status      read data (0 for writes/failures), status
//   wb_adr_o/wb_dat_o/wb_we_o Wishbone address, write data, write enable
//   wb_cyc_o/wb_stb_o         Wishbone cycle/strobe
//   wb_cti_o/wb_bte_o         constant classic-cycle tags
//   wb_dat_i                  Wishbone read data
//   wb_ack_i/wb_err_i/wb_rty_i slave terminations
module wb_master_bridge #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [WIDTH-1:0] cmd_dat,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_dat,
    output logic [1:0]       resp_status,
    output logic [31:0]      wb_adr_o,
    output logic [WIDTH-1:0] wb_dat_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [WIDTH-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusErr     = 2'b01;
    localparam logic [1:0] StatusRetry   = 2'b10;
    localparam logic [1:0] StatusTimeout = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StBackoff,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      adr_q, adr_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             we_q, we_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WIDTH-1:0] resp_dat_q, resp_dat_d;
    logic [1:0]       resp_status_q, resp_status_d;

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_expire;

    // Expire on the silent cycle in which the count would reach TIMEOUT_CYCLES,
    // so the bus phase lasts exactly TIMEOUT_CYCLES cycles.
    assign tmo_expire = (32'(tmo_q) + 32'd1) >= TIMEOUT_CYCLES;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d       = state_q;
        adr_d         = adr_q;
        dat_d         = dat_q;
        we_d          = we_q;
        retry_d       = retry_q;
        resp_dat_d    = resp_dat_q;
        resp_status_d = resp_status_q;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
        tmo_d         = tmo_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    we_d    = cmd_we;
                    retry_d = '0;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = StBus;
                end
            end

            StBus: begin
                // Priority err > ack > rty.
                if (wb_err_i) begin
                    resp_dat_d    = '0;
                    resp_status_d = StatusErr;
                    state_d       = StResp;
                end else if (wb_ack_i) begin
                    resp_dat_d    = we_q ? '0 : wb_dat_i;
                    resp_status_d = StatusOk;
                    state_d       = StResp;
                end else if (wb_rty_i) begin
                    if (retry_q == MaxRetry) begin
                        resp_dat_d    = '0;
                        resp_status_d = StatusRetry;
                        state_d       = StResp;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = StBackoff;
                    end
                end else begin
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                    if (tmo_expire) begin
                        resp_dat_d    = '0;
                        resp_status_d = StatusTimeout;
                        state_d       = StResp;
                    end else if (tmo_q != TmoMax) begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
            end

            StBackoff: begin
                // Re-issue the same command; each attempt gets a fresh timeout.
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = StBus;
            end

            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q       <= StIdle;
            adr_q         <= '0;
            dat_q         <= '0;
            we_q          <= 1'b0;
            retry_q       <= '0;
            resp_dat_q    <= '0;
            resp_status_q <= '0;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            we_q          <= we_d;
            retry_q       <= retry_d;
            resp_dat_q    <= resp_dat_d;
            resp_status_q <= resp_status_d;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            tmo_q         <= tmo_d;
`endif
        end
    end

    // Handshake and bus strobes decode straight from state: cyc/stb fall at
    // the same edge that leaves the bus phase, including reset.
    assign cmd_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StResp);
    assign wb_cyc_o    = (state_q == StBus);
    assign wb_stb_o    = (state_q == StBus);
    assign resp_dat    = resp_dat_q;
    assign resp_status = resp_status_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_cti_o    = 3'b000;
    assign wb_bte_o    = 2'b00;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Command-driven Wishbone classic master: the initiator end of the peripheral bus, driving slaves such as the GPIO port peripheral.
- Accepts a single read/write command over a valid/ready handshake and runs one Wishbone classic single cycle.
- Handles ack/err/rty from the slave, with a bounded retry count and an optional timeout.
- Returns read data and a status code over a valid/ready response channel.
- Used by test sequencers and small controllers to access peripheral registers.

Parameters:
- WIDTH, 8: data width of the command, response and Wishbone data buses.
- MAX_RETRY, 3: number of re-issues after rty before giving up (0 = no retries).
- TIMEOUT_CYCLES, 255: bus-phase cycles per attempt before abort. Only used with the optional feature.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  target address.
- cmd_dat  in  WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_dat  out  WIDTH  read data; 0 for writes and failures.
- resp_status  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  WIDTH  Wishbone write data.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  constant 3'b000.
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  WIDTH  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry.

Behaviour:
- States:
  - IDLE: cmd_ready=1.
  - BUS: cyc=stb=1.
  - BACKOFF: cyc=stb=0 for exactly 1 cycle.
  - RESP: resp_valid=1.
- Reset: state IDLE; cmd_ready=1. The following are all 0: resp_valid, resp_dat, resp_status, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, retry count, timeout count.
- Reset mid-operation (any state): cyc/stb drop at the reset edge; the pending command and response are discarded with no response emitted.
- IDLE:
  - cmd_valid & cmd_ready at edge N captures adr/dat/we into wb_adr_o/wb_dat_o/wb_we_o.
  - cyc=stb=1 from cycle N+1 (state BUS).
  - Retry count and timeout count cleared.
- BUS: sample slave responses each cycle. Priority err > ack > rty when several are asserted together.
  - err: next edge cyc=stb=0; RESP with status 01; resp_dat=0.
  - ack: next edge cyc=stb=0; RESP with status 00; resp_dat = wb_dat_i if read, 0 if write.
  - A slave with combinational ack (ack = stb) completes in exactly 1 BUS cycle, so cmd accept to resp_valid is 2 cycles.
  - rty with retry count < MAX_RETRY: retry count +1, go to BACKOFF. BACKOFF returns to BUS with the same adr/dat/we, and the timeout count is cleared.
  - rty with retry count == MAX_RETRY: RESP with status 10.
  - No response: hold cyc/stb and all bus outputs stable.
- RESP:
  - resp_valid, resp_dat and resp_status are held stable until resp_ready.
  - On resp_valid & resp_ready, next state IDLE; resp_valid=0 next cycle.
  - cmd_ready=0 throughout RESP, so only one transaction is ever outstanding.
- wb_adr_o/wb_dat_o/wb_we_o keep their last values outside BUS; slaves must qualify them with cyc/stb.
- Slave responses while cyc=0 are ignored.
- Counters saturate and do not wrap.
  - Retry count width: clog2(MAX_RETRY+1), minimum 1.
  - Timeout count width: clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro WB_MASTER_BRIDGE_TIMEOUT_EN.
- Defined:
  - Timeout count increments every BUS cycle with no ack/err/rty.
  - When the count reaches TIMEOUT_CYCLES with no response, the next edge drops cyc/stb and enters RESP with status 11, resp_dat=0.
  - A response in the same cycle the count reaches TIMEOUT_CYCLES takes precedence over the timeout.
- Not defined: no timeout logic; the bridge waits in BUS indefinitely; status 11 is never produced.

Test Plan:
- Read, combinational-ack slave returning 8'hA5 at adr 0x00 -> cyc/stb high exactly 1 cycle; resp_valid 2 cycles after accept; resp_dat=8'hA5, status 00.
- Write 8'h3C to adr 0x04, slave acks after 3 wait cycles -> wb_dat_o=8'h3C and wb_we_o=1 stable 4 cycles; status 00, resp_dat=0; cmd_ready low until resp handshake.
- Slave asserts rty on every attempt, MAX_RETRY=3 -> 4 bus attempts separated by 1-cycle cyc gaps; status 10. rty twice then ack -> 3 attempts, status 00.
- Slave asserts err and ack in the same cycle -> status 01, resp_dat=0. resp_ready held low 5 cycles -> resp outputs stable, no new cmd accepted.
- Silent slave with macro defined, TIMEOUT_CYCLES=16 -> status 11 after 16 BUS cycles, cyc drops. Macro undefined -> cyc stays high 1000 cycles, no resp_valid.
- wb_rst asserted in 2nd BUS cycle of a waiting read -> next cycle cyc=stb=0, resp_valid=0, cmd_ready=1; later ack ignored.
